// File: rtl/game_ctrl_if.sv
// Bus between the round sequencer and its surroundings: controls and keys in,
// ROM address/data, and the LED/status outputs.
interface game_ctrl_if;
  logic       start;
  logic       key_valid;
  logic [3:0] key;
  logic [3:0] rom_data;
  logic [3:0] rom_addr;
  logic [3:0] round;
  logic [3:0] leds;
  logic       showing;
  logic       await_input;
  logic       win;
  logic       lose;

  modport master (
    output start, key_valid, key, rom_data,
    input  rom_addr, round, leds, showing, await_input, win, lose
  );

  modport slave (
    input  start, key_valid, key, rom_data,
    output rom_addr, round, leds, showing, await_input, win, lose
  );
endinterface

// File: rtl/game_ctrl.sv
// Memory-game round sequencer: plays back ROM[0..round] on the LEDs, then checks
// the player's keys against the same entries, advancing rounds until WIN or LOSE.
module game_ctrl #(
  parameter int unsigned DISP_CYCLES    = 8,
  parameter int unsigned GAP_CYCLES     = 2,
  parameter int unsigned MAX_ROUND      = 15,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input logic       clk,
  input logic       R,
  game_ctrl_if.slave bus
);

  localparam int unsigned MaxDg  = (DISP_CYCLES > GAP_CYCLES) ? DISP_CYCLES : GAP_CYCLES;
  localparam int unsigned MaxCyc = (MaxDg > TIMEOUT_CYCLES) ? MaxDg : TIMEOUT_CYCLES;
  localparam int unsigned TimerW = $clog2(MaxCyc + 1);

  localparam logic [TimerW-1:0] DispLast = TimerW'(DISP_CYCLES - 1);
  localparam logic [TimerW-1:0] GapLast  = TimerW'(GAP_CYCLES - 1);
  localparam logic [TimerW-1:0] ToLast   = TimerW'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]        RoundMax = 4'(MAX_ROUND);

  typedef enum logic [2:0] {
    StIdle, StShowOn, StShowOff, StWaitIn, StRoundUp, StWin, StLose
  } state_e;

  state_e             state_q, state_d;
  logic [3:0]         idx_q, idx_d;
  logic [3:0]         round_q, round_d;
  logic [TimerW-1:0]  timer_q, timer_d;

  always_ff @(posedge clk) begin
    if (R) begin
      state_q <= StIdle;
      idx_q   <= '0;
      round_q <= '0;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      round_q <= round_d;
      timer_q <= timer_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    round_d = round_q;
    timer_d = timer_q;
    unique case (state_q)
      StIdle, StWin, StLose: begin
        if (bus.start) begin
          state_d = StShowOn;
          idx_d   = '0;
          round_d = '0;
          timer_d = '0;
        end
      end
      StShowOn: begin
        if (timer_q == DispLast) begin
          state_d = StShowOff;
          timer_d = '0;
        end else begin
          timer_d = timer_q + TimerW'(1);
        end
      end
      StShowOff: begin
        if (timer_q == GapLast) begin
          timer_d = '0;
          if (idx_q == round_q) begin
            state_d = StWaitIn;
            idx_d   = '0;
          end else begin
            state_d = StShowOn;
            idx_d   = idx_q + 4'd1;
          end
        end else begin
          timer_d = timer_q + TimerW'(1);
        end
      end
      StWaitIn: begin
        // A key arriving on the timeout cycle is judged as a key, not a timeout.
        if (bus.key_valid) begin
          timer_d = '0;
          if (bus.key != bus.rom_data) begin
            state_d = StLose;
          end else if (idx_q == round_q) begin
            state_d = StRoundUp;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end else if (timer_q == ToLast) begin
          state_d = StLose;
        end else begin
          timer_d = timer_q + TimerW'(1);
        end
      end
      StRoundUp: begin
        if (round_q == RoundMax) begin
          state_d = StWin;
        end else begin
          state_d = StShowOn;
          round_d = round_q + 4'd1;
          idx_d   = '0;
          timer_d = '0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign bus.rom_addr    = idx_q;
  assign bus.round       = round_q;
  assign bus.leds        = (state_q == StShowOn) ? bus.rom_data : 4'h0;
  assign bus.showing     = (state_q == StShowOn) || (state_q == StShowOff);
  assign bus.await_input = (state_q == StWaitIn);
  assign bus.win         = (state_q == StWin);
  assign bus.lose        = (state_q == StLose);

endmodule

// File: tb/tb_game_ctrl.sv
// Directed bench for game_ctrl: instance A uses default timing, instance B uses a
// short timeout and MAX_ROUND=1; sel_b steers stimulus and observation to one of them.
module tb_game_ctrl;
  logic       clk = 1'b0;
  logic       R;
  logic       start;
  logic       key_valid;
  logic [3:0] key;
  logic       sel_b;
  logic [3:0] rom [16];
  int         nvec = 0;
  int         nerr = 0;

  always #5 clk = ~clk;

  game_ctrl_if ifa ();
  game_ctrl_if ifb ();

  assign ifa.start     = start & ~sel_b;
  assign ifa.key_valid = key_valid & ~sel_b;
  assign ifa.key       = key;
  assign ifa.rom_data  = rom[ifa.rom_addr];
  assign ifb.start     = start & sel_b;
  assign ifb.key_valid = key_valid & sel_b;
  assign ifb.key       = key;
  assign ifb.rom_data  = rom[ifb.rom_addr];

  game_ctrl u_a (
    .clk (clk),
    .R   (R),
    .bus (ifa.slave)
  );

  game_ctrl #(
    .TIMEOUT_CYCLES (4),
    .MAX_ROUND      (1)
  ) u_b (
    .clk (clk),
    .R   (R),
    .bus (ifb.slave)
  );

  logic [3:0] o_leds, o_addr, o_round;
  logic       o_showing, o_await, o_win, o_lose;
  logic [15:0] pk_a, pk_b;

  assign o_leds    = sel_b ? ifb.leds        : ifa.leds;
  assign o_addr    = sel_b ? ifb.rom_addr    : ifa.rom_addr;
  assign o_round   = sel_b ? ifb.round       : ifa.round;
  assign o_showing = sel_b ? ifb.showing     : ifa.showing;
  assign o_await   = sel_b ? ifb.await_input : ifa.await_input;
  assign o_win     = sel_b ? ifb.win         : ifa.win;
  assign o_lose    = sel_b ? ifb.lose        : ifa.lose;
  assign pk_a = {ifa.leds, ifa.showing, ifa.await_input, ifa.win, ifa.lose,
                 ifa.rom_addr, ifa.round};
  assign pk_b = {ifb.leds, ifb.showing, ifb.await_input, ifb.win, ifb.lose,
                 ifb.rom_addr, ifb.round};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_game();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic press(input logic [3:0] k);
    key_valid = 1'b1;
    key       = k;
    tick();
    key_valid = 1'b0;
  endtask

  task automatic wait_await(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400 && !ok; i++) begin
      if (o_await) ok = 1'b1;
      else tick();
    end
  endtask

  task automatic test_reset();
    R = 1'b1;
    tick();
    tick();
    R = 1'b0;
    for (int c = 0; c < 20; c++) begin
      nvec++;
      if (pk_a !== 16'h0) begin
        nerr++;
        $display("FAIL reset_idle_a cycle %0d: got %h want 0000", c, pk_a);
      end
      nvec++;
      if (pk_b !== 16'h0) begin
        nerr++;
        $display("FAIL reset_idle_b cycle %0d: got %h want 0000", c, pk_b);
      end
      tick();
    end
  endtask

  task automatic test_playback_r0();
    logic [5:0] exp_v;
    sel_b = 1'b0;
    start_game();
    for (int c = 1; c <= 11; c++) begin
      if (c <= 8)       exp_v = {rom[0], 1'b1, 1'b0};
      else if (c <= 10) exp_v = {4'h0, 1'b1, 1'b0};
      else              exp_v = {4'h0, 1'b0, 1'b1};
      nvec++;
      if ({o_leds, o_showing, o_await} !== exp_v) begin
        nerr++;
        $display("FAIL playback_r0 cycle %0d: got %b want %b", c,
                 {o_leds, o_showing, o_await}, exp_v);
      end
      if (c < 11) tick();
    end
  endtask

  task automatic test_correct_play();
    logic [8:0] exp_v;
    press(rom[0]);
    nvec++;
    if ({o_showing, o_await, o_round} !== 6'b00_0000) begin
      nerr++;
      $display("FAIL round_up_r0: got %b want 000000", {o_showing, o_await, o_round});
    end
    tick();
    for (int c = 0; c < 20; c++) begin
      if (c < 8)       exp_v = {rom[0], 1'b1, 4'h1};
      else if (c < 10) exp_v = {4'h0, 1'b1, 4'h1};
      else if (c < 18) exp_v = {rom[1], 1'b1, 4'h1};
      else             exp_v = {4'h0, 1'b1, 4'h1};
      nvec++;
      if ({o_leds, o_showing, o_round} !== exp_v) begin
        nerr++;
        $display("FAIL playback_r1 cycle %0d: got %b want %b", c,
                 {o_leds, o_showing, o_round}, exp_v);
      end
      tick();
    end
    nvec++;
    if ({o_await, o_addr} !== 5'b1_0000) begin
      nerr++;
      $display("FAIL await_r1: got %b want 10000", {o_await, o_addr});
    end
    press(rom[0]);
    nvec++;
    if ({o_await, o_addr} !== 5'b1_0001) begin
      nerr++;
      $display("FAIL key1_idx_r1: got %b want 10001", {o_await, o_addr});
    end
    press(rom[1]);
    tick();
    nvec++;
    if ({o_showing, o_round, o_addr} !== 9'b1_0010_0000) begin
      nerr++;
      $display("FAIL advance_r2: got %b want 100100000", {o_showing, o_round, o_addr});
    end
  endtask

  task automatic test_wrong_key();
    bit ok;
    R = 1'b1;
    tick();
    R = 1'b0;
    sel_b = 1'b0;
    start_game();
    wait_await(ok);
    press(rom[0]);
    wait_await(ok);
    nvec++;
    if (!ok || o_round !== 4'h1) begin
      nerr++;
      $display("FAIL wrong_reach_r1: got round %h ok %0d want round 1 ok 1", o_round, ok);
    end
    press(rom[0]);
    press(4'h8);
    nvec++;
    if ({o_lose, o_await} !== 2'b10) begin
      nerr++;
      $display("FAIL wrong_key_lose: got %b want 10", {o_lose, o_await});
    end
    for (int i = 0; i < 3; i++) begin
      press(rom[1]);
      nvec++;
      if ({o_lose, o_await, o_round, o_addr} !== 10'b10_0001_0001) begin
        nerr++;
        $display("FAIL lose_hold %0d: got %b want 1000010001", i,
                 {o_lose, o_await, o_round, o_addr});
      end
    end
  endtask

  task automatic test_timeout();
    bit ok;
    sel_b = 1'b1;
    R = 1'b1;
    tick();
    R = 1'b0;
    start_game();
    wait_await(ok);
    for (int i = 1; i <= 3; i++) begin
      tick();
      nvec++;
      if ({o_await, o_lose} !== 2'b10) begin
        nerr++;
        $display("FAIL timeout_wait %0d: got %b want 10", i, {o_await, o_lose});
      end
    end
    tick();
    nvec++;
    if ({o_await, o_lose} !== 2'b01) begin
      nerr++;
      $display("FAIL timeout_lose: got %b want 01", {o_await, o_lose});
    end
    start_game();
    wait_await(ok);
    tick();
    tick();
    tick();
    press(rom[0]);
    nvec++;
    if ({o_lose, o_await, o_showing} !== 3'b000) begin
      nerr++;
      $display("FAIL key_beats_timeout: got %b want 000", {o_lose, o_await, o_showing});
    end
    tick();
    nvec++;
    if ({o_showing, o_round} !== 5'b1_0001) begin
      nerr++;
      $display("FAIL precedence_next_round: got %b want 10001", {o_showing, o_round});
    end
  endtask

  task automatic test_win_restart();
    bit ok;
    sel_b = 1'b1;
    wait_await(ok);
    press(rom[0]);
    press(rom[1]);
    tick();
    nvec++;
    if ({o_win, o_lose, o_round} !== 6'b10_0001) begin
      nerr++;
      $display("FAIL win_reached: got %b want 100001", {o_win, o_lose, o_round});
    end
    press(rom[0]);
    tick();
    nvec++;
    if ({o_win, o_round, o_addr} !== 9'b1_0001_0001) begin
      nerr++;
      $display("FAIL win_hold: got %b want 100010001", {o_win, o_round, o_addr});
    end
    start_game();
    nvec++;
    if ({o_win, o_round, o_showing, o_leds} !== {1'b0, 4'h0, 1'b1, rom[0]}) begin
      nerr++;
      $display("FAIL restart: got %b want %b", {o_win, o_round, o_showing, o_leds},
               {1'b0, 4'h0, 1'b1, rom[0]});
    end
    tick();
    tick();
    R = 1'b1;
    tick();
    R = 1'b0;
    nvec++;
    if (pk_b !== 16'h0) begin
      nerr++;
      $display("FAIL reset_mid_play: got %h want 0000", pk_b);
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) rom[i] = 4'(i + 1);
    R         = 1'b1;
    start     = 1'b0;
    key_valid = 1'b0;
    key       = 4'h0;
    sel_b     = 1'b0;
    test_reset();
    test_playback_r0();
    test_correct_play();
    test_wrong_key();
    test_timeout();
    test_win_restart();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
